// File: rtl/spi_flash_reader.sv
// Single-byte SPI flash reader (mode 0, MSB first) answering fd_valid/fd_ready requests.
// Define SPI_FLASH_FAST_READ_EN to use FAST READ (0x0B) with 8 dummy clocks after the address.
module spi_flash_reader #(
    parameter int          CLK_DIV  = 2,
    parameter logic [7:0]  READ_CMD = 8'h03
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [23:0] fd_address,
    input  logic        fd_valid,
    output logic [7:0]  fd,
    output logic        fd_ready,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0] OPCODE      = 8'h0B;
    localparam logic [5:0] LAST_PERIOD = 6'd47;
    localparam logic [5:0] DATA_FIRST  = 6'd40;
`else
    localparam logic [7:0] OPCODE      = READ_CMD;
    localparam logic [5:0] LAST_PERIOD = 6'd39;
    localparam logic [5:0] DATA_FIRST  = 6'd32;
`endif

    localparam int            HW   = $clog2(CLK_DIV) + 1;
    localparam logic [HW-1:0] HMAX = HW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CS_SETUP = 3'd1,
        SHIFT    = 3'd2,
        CS_HOLD  = 3'd3,
        DONE     = 3'd4,
        WAIT_REL = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [5:0]    bcnt_q, bcnt_d;
    logic [31:0]   sr_q, sr_d;
    logic [7:0]    rx_q, rx_d;
    logic [7:0]    fd_q, fd_d;
    logic          fd_ready_q, fd_ready_d;
    logic          cs_n_q, cs_n_d;
    logic          sclk_q, sclk_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            hcnt_q     <= '0;
            bcnt_q     <= '0;
            sr_q       <= '0;
            rx_q       <= '0;
            fd_q       <= '0;
            fd_ready_q <= 1'b0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            bcnt_q     <= bcnt_d;
            sr_q       <= sr_d;
            rx_q       <= rx_d;
            fd_q       <= fd_d;
            fd_ready_q <= fd_ready_d;
            cs_n_q     <= cs_n_d;
            sclk_q     <= sclk_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hcnt_d     = hcnt_q;
        bcnt_d     = bcnt_q;
        sr_d       = sr_q;
        rx_d       = rx_q;
        fd_d       = fd_q;
        fd_ready_d = 1'b0;
        cs_n_d     = cs_n_q;
        sclk_d     = sclk_q;

        case (state_q)
            IDLE: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                if (fd_valid) begin
                    sr_d    = {OPCODE, fd_address};
                    cs_n_d  = 1'b0;
                    hcnt_d  = '0;
                    bcnt_d  = '0;
                    rx_d    = '0;
                    state_d = CS_SETUP;
                end
            end
            CS_SETUP: begin
                if (hcnt_q == HMAX) begin
                    hcnt_d  = '0;
                    state_d = SHIFT;
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            SHIFT: begin
                // Sample on the first cycle of the high half; the flash changes MISO only on falling SCLK.
                if (sclk_q && hcnt_q == '0 && bcnt_q >= DATA_FIRST)
                    rx_d = {rx_q[6:0], spi_miso};
                if (hcnt_q == HMAX) begin
                    hcnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        // MOSI is sr_q[31]; zeros shift in, so it reads 0 once the address is out.
                        sr_d   = {sr_q[30:0], 1'b0};
                        if (bcnt_q == LAST_PERIOD)
                            state_d = CS_HOLD;
                        else
                            bcnt_d = bcnt_q + 6'd1;
                    end
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            CS_HOLD: begin
                if (hcnt_q == HMAX) begin
                    hcnt_d     = '0;
                    cs_n_d     = 1'b1;
                    fd_d       = rx_q;
                    fd_ready_d = 1'b1;
                    state_d    = DONE;
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            DONE: begin
                state_d = WAIT_REL;
            end
            WAIT_REL: begin
                if (!fd_valid)
                    state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
                sr_d    = '0;
            end
        endcase
    end

    assign fd       = fd_q;
    assign fd_ready = fd_ready_q;
    assign spi_cs_n = cs_n_q;
    assign spi_sclk = sclk_q;
    assign spi_mosi = sr_q[31];

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader with a behavioural mode-0 serial flash model.
module tb_spi_flash_reader;

`ifdef SPI_FLASH_FAST_READ_EN
    localparam int         CLK_DIV = 1;
    localparam logic [7:0] OPC     = 8'h0B;
    localparam int         PERIODS = 48;
    localparam int         LAT     = 99;
`else
    localparam int         CLK_DIV = 2;
    localparam logic [7:0] OPC     = 8'h03;
    localparam int         PERIODS = 40;
    localparam int         LAT     = 165;
`endif
    localparam int DSTART = PERIODS - 8;

    logic        clk;
    logic        rstn;
    logic [23:0] fd_address;
    logic        fd_valid;
    logic [7:0]  fd;
    logic        fd_ready;
    logic        spi_cs_n;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso;

    spi_flash_reader #(.CLK_DIV(CLK_DIV)) u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .fd_address (fd_address),
        .fd_valid   (fd_valid),
        .fd         (fd),
        .fd_ready   (fd_ready),
        .spi_cs_n   (spi_cs_n),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flash model: shifts in command/address on rising SCLK, drives data on falling SCLK.
    int          cs_falls    = 0;
    int          seen_falls  = 0;
    int          rises       = 0;
    int          sclk_total  = 0;
    logic [31:0] cmd_word    = '0;
    logic        mosi_bad    = 1'b0;
    logic [7:0]  mem_byte;

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        case (a)
            24'h000123: return 8'hA5;
            24'hFFFFFF: return 8'h3C;
            default:    return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    always @(negedge spi_cs_n) cs_falls++;

    always @(posedge spi_sclk) begin
        sclk_total++;
        if (cs_falls != seen_falls) begin
            seen_falls = cs_falls;
            rises      = 0;
            cmd_word   = '0;
            mosi_bad   = 1'b0;
        end
        if (!spi_cs_n) begin
            if (rises < 32) cmd_word = {cmd_word[30:0], spi_mosi};
            else if (spi_mosi) mosi_bad = 1'b1;
            rises++;
        end
    end

    always @(negedge spi_sclk) begin
        if (!spi_cs_n && rises >= DSTART && rises < DSTART + 8) begin
            mem_byte = flash_byte(cmd_word[23:0]);
            spi_miso <= mem_byte[3'(7 - (rises - DSTART))];
        end
    end

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic do_read(input string tag, input logic [23:0] addr, input logic [7:0] exp,
                           input int drop_at, input int chg_at);
        int         f0;
        int         rdy_cnt;
        int         rdy_at;
        logic       cs_at_rdy;
        logic       fd_moved;
        logic [7:0] fd_prev;
        f0        = cs_falls;
        rdy_cnt   = 0;
        rdy_at    = -1;
        cs_at_rdy = 1'b0;
        fd_moved  = 1'b0;
        fd_prev   = fd;
        fd_address = addr;
        fd_valid   = 1'b1;
        for (int n = 0; n < LAT + 30; n++) begin
            @(negedge clk);
            if (fd_ready) begin
                rdy_cnt++;
                rdy_at    = n;
                cs_at_rdy = spi_cs_n;
            end
            if (!fd_ready && fd !== ((rdy_cnt == 0) ? fd_prev : exp)) fd_moved = 1'b1;
            @(posedge clk);
            #1;
            if (n == drop_at) fd_valid = 1'b0;
            if (n == chg_at) fd_address = 24'h00ABCD;
        end
        fd_valid = 1'b0;
        chk({tag, "_rdy_cnt"},   32'(rdy_cnt),        32'd1);
        chk({tag, "_rdy_at"},    32'(rdy_at),         32'(LAT));
        chk({tag, "_fd"},        32'(fd),             32'(exp));
        chk({tag, "_cmd"},       cmd_word,            {OPC, addr});
        chk({tag, "_rises"},     32'(rises),          32'(PERIODS));
        chk({tag, "_cs_falls"},  32'(cs_falls - f0),  32'd1);
        chk({tag, "_cs_at_rdy"}, 32'(cs_at_rdy),      32'd1);
        chk({tag, "_fd_hold"},   32'(fd_moved),       32'd0);
        chk({tag, "_mosi_tail"}, 32'(mosi_bad),       32'd0);
    endtask

    initial begin
        int   f0;
        int   s0;
        logic cs_low;
        rstn       = 1'b0;
        fd_valid   = 1'b0;
        fd_address = '0;
        spi_miso   = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_fd",       32'(fd),       32'h00);
        chk("rst_fd_ready", 32'(fd_ready), 32'd0);
        chk("rst_cs_n",     32'(spi_cs_n), 32'd1);
        chk("rst_sclk",     32'(spi_sclk), 32'd0);
        chk("rst_mosi",     32'(spi_mosi), 32'd0);

        @(posedge clk);
        #1 rstn = 1'b1;
        f0     = cs_falls;
        s0     = sclk_total;
        cs_low = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (!spi_cs_n) cs_low = 1'b1;
        end
        chk("idle_cs_falls", 32'(cs_falls - f0),   32'd0);
        chk("idle_sclk",     32'(sclk_total - s0), 32'd0);
        chk("idle_cs_low",   32'(cs_low),          32'd0);
        @(posedge clk);
        #1;

        do_read("basic",  24'h000123, 8'hA5, LAT,      -1);
        do_read("held",   24'h000123, 8'hA5, LAT + 20, -1);
        do_read("ffffff", 24'hFFFFFF, 8'h3C, LAT,      -1);
        do_read("chg",    24'h000123, 8'hA5, 5,        30);

        fd_address = 24'h000123;
        fd_valid   = 1'b1;
        repeat (60) begin
            @(posedge clk);
            #1;
        end
        rstn = 1'b0;
        #1;
        chk("midrst_cs_n",     32'(spi_cs_n), 32'd1);
        chk("midrst_sclk",     32'(spi_sclk), 32'd0);
        chk("midrst_fd",       32'(fd),       32'h00);
        chk("midrst_fd_ready", 32'(fd_ready), 32'd0);
        fd_valid = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;
        do_read("post_rst", 24'h000456, 8'h0C, LAT, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
